// File: rtl/fractal_sync_1d_rf_sched.sv
// Round-robin scheduler sharing one fractal_sync_1d_local_rf among N_REQ barrier requesters.
// Define FRACTAL_SYNC_RF_SCHED_STATS_EN to add saturating sync/error/defer counters.

module fractal_sync_1d_rf_sched_slot #(
  parameter int ID_WIDTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid,
  input  logic [ID_WIDTH-1:0] req_id,
  input  logic                gnt,
  input  logic                gnt_done,
  input  logic                gnt_err,
  input  logic                rel,
  output logic                ready,
  output logic                is_issue,
  output logic                is_wait,
  output logic [ID_WIDTH-1:0] id,
  output logic                rsp_valid,
  output logic                rsp_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] id_d;
  logic                rsp_valid_d, rsp_err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      id        <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      id        <= id_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = ISSUE;
        id_d    = req_id;
      end
      ISSUE: if (gnt) begin
        if (gnt_done) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = gnt_err;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (rel) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready    = (state_q == IDLE);
  assign is_issue = (state_q == ISSUE);
  assign is_wait  = (state_q == WAIT);
endmodule

module fractal_sync_1d_rf_sched #(
  parameter int N_REQ    = 4,
  parameter int N_PORTS  = 2,
  parameter int ID_WIDTH = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [N_REQ-1:0]                  req_valid_i,
  input  logic [N_REQ-1:0][ID_WIDTH-1:0]    req_id_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  output logic [N_REQ-1:0]                  rsp_valid_o,
  output logic [N_REQ-1:0]                  rsp_err_o,
  output logic [N_PORTS-1:0][ID_WIDTH-1:0]  rf_id_o,
  output logic [N_PORTS-1:0]                rf_check_o,
  input  logic [N_PORTS-1:0]                rf_present_i,
  input  logic [N_PORTS-1:0]                rf_id_err_i,
  input  logic [N_PORTS-1:0]                rf_bypass_i,
  input  logic [N_PORTS-1:0]                rf_ignore_i
`ifdef FRACTAL_SYNC_RF_SCHED_STATS_EN
  ,
  output logic [31:0]                       stat_sync_o,
  output logic [15:0]                       stat_err_o,
  output logic [31:0]                       stat_defer_o
`endif
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int NIDS  = 2 ** ID_WIDTH;

  if (N_PORTS < 2) begin : g_chk_ports
    $error("N_PORTS must be >= 2");
  end
  if (N_REQ < N_PORTS) begin : g_chk_req
    $error("N_REQ must be >= N_PORTS");
  end
  if (NIDS < N_PORTS) begin : g_chk_id
    $error("2**ID_WIDTH must be >= N_PORTS");
  end

  logic [N_REQ-1:0]                 is_issue, is_wait, wait_hit;
  logic [N_REQ-1:0]                 grant, gnt_done, gnt_err, rel;
  logic [N_REQ-1:0][ID_WIDTH-1:0]   slot_id;
  logic [N_PORTS-1:0]               port_vld;
  logic [N_PORTS-1:0][PTR_W-1:0]    port_slot;
  logic [N_PORTS-1:0][ID_WIDTH-1:0] port_id;
  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic                             starved;
  int                               gnt_cnt;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    fractal_sync_1d_rf_sched_slot #(.ID_WIDTH(ID_WIDTH)) u_slot (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_valid (req_valid_i[i]),
      .req_id    (req_id_i[i]),
      .gnt       (grant[i]),
      .gnt_done  (gnt_done[i]),
      .gnt_err   (gnt_err[i]),
      .rel       (rel[i]),
      .ready     (req_ready_o[i]),
      .is_issue  (is_issue[i]),
      .is_wait   (is_wait[i]),
      .id        (slot_id[i]),
      .rsp_valid (rsp_valid_o[i]),
      .rsp_err   (rsp_err_o[i])
    );
  end

  // A candidate whose id already has a WAIT partner must not share a cycle with another grant on that id.
  always_comb begin
    wait_hit = '0;
    for (int i = 0; i < N_REQ; i++)
      for (int j = 0; j < N_REQ; j++)
        if (is_wait[j] && slot_id[j] == slot_id[i]) wait_hit[i] = 1'b1;
  end

  always_comb begin
    int   idx;
    logic blocked;
    port_vld  = '0;
    port_slot = '0;
    port_id   = '0;
    grant     = '0;
    starved   = 1'b0;
    rr_ptr_d  = rr_ptr_q;
    gnt_cnt   = 0;
    idx       = 0;
    blocked   = 1'b0;
    for (int o = 0; o < N_REQ; o++) begin
      idx = (int'(rr_ptr_q) + o) % N_REQ;
      if (is_issue[idx]) begin
        blocked = 1'b0;
        if (wait_hit[idx])
          for (int k = 0; k < N_PORTS; k++)
            if (k < gnt_cnt && port_id[k] == slot_id[idx]) blocked = 1'b1;
        if (blocked || gnt_cnt >= N_PORTS) begin
          starved = 1'b1;
        end else begin
          grant[idx]         = 1'b1;
          port_vld[gnt_cnt]  = 1'b1;
          port_slot[gnt_cnt] = PTR_W'(idx);
          port_id[gnt_cnt]   = slot_id[idx];
          gnt_cnt            = gnt_cnt + 1;
          rr_ptr_d           = PTR_W'((idx + 1) % N_REQ);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

  // Idle ports get distinct ids unused by any grant, so they cannot alias a live check.
  always_comb begin
    int   cnt;
    logic used;
    rf_id_o    = port_id;
    rf_check_o = port_vld;
    cnt        = 0;
    used       = 1'b0;
    for (int v = 0; v < NIDS; v++) begin
      used = 1'b0;
      for (int k = 0; k < N_PORTS; k++)
        if (port_vld[k] && port_id[k] == ID_WIDTH'(v)) used = 1'b1;
      if (!used) begin
        for (int k = 0; k < N_PORTS; k++)
          if (!port_vld[k] && (k - gnt_cnt) == cnt) rf_id_o[k] = ID_WIDTH'(v);
        cnt = cnt + 1;
      end
    end
  end

  always_comb begin
    gnt_done = '0;
    gnt_err  = '0;
    rel      = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (port_vld[k]) begin
        if (rf_id_err_i[k]) begin
          gnt_done[port_slot[k]] = 1'b1;
          gnt_err[port_slot[k]]  = 1'b1;
        end else if (rf_bypass_i[k] || rf_ignore_i[k]) begin
          gnt_done[port_slot[k]] = 1'b1;
        end else if (rf_present_i[k]) begin
          gnt_done[port_slot[k]] = 1'b1;
          for (int j = 0; j < N_REQ; j++)
            if (is_wait[j] && slot_id[j] == port_id[k]) rel[j] = 1'b1;
        end
      end
    end
  end

`ifdef FRACTAL_SYNC_RF_SCHED_STATS_EN
  localparam int CNT_W = $clog2(N_REQ + 1);
  logic [CNT_W-1:0] n_sync, n_err;
  logic [32:0]      sync_sum, defer_sum;
  logic [16:0]      err_sum;

  always_comb begin
    n_sync = '0;
    n_err  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      n_sync = n_sync + CNT_W'(rsp_valid_o[i] & ~rsp_err_o[i]);
      n_err  = n_err  + CNT_W'(rsp_valid_o[i] &  rsp_err_o[i]);
    end
  end

  assign sync_sum  = {1'b0, stat_sync_o}  + 33'(n_sync);
  assign err_sum   = {1'b0, stat_err_o}   + 17'(n_err);
  assign defer_sum = {1'b0, stat_defer_o} + 33'(starved);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_sync_o  <= '0;
      stat_err_o   <= '0;
      stat_defer_o <= '0;
    end else begin
      stat_sync_o  <= sync_sum[32]  ? '1 : sync_sum[31:0];
      stat_err_o   <= err_sum[16]   ? '1 : err_sum[15:0];
      stat_defer_o <= defer_sum[32] ? '1 : defer_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_fractal_sync_1d_rf_sched.sv
// Bench for fractal_sync_1d_rf_sched: behavioural RF model plus response scoreboard.
module tb_fractal_sync_1d_rf_sched;
  localparam int N_REQ = 4, N_PORTS = 2, ID_WIDTH = 2;

  logic                             clk = 1'b0;
  logic                             rst_ni = 1'b0;
  logic [N_REQ-1:0]                 req_valid = '0;
  logic [N_REQ-1:0][ID_WIDTH-1:0]   req_id = '0;
  logic [N_REQ-1:0]                 req_ready, rsp_valid, rsp_err;
  logic [N_PORTS-1:0][ID_WIDTH-1:0] rf_id;
  logic [N_PORTS-1:0]               rf_check, rf_present, rf_id_err, rf_bypass, rf_ignore;
`ifdef FRACTAL_SYNC_RF_SCHED_STATS_EN
  logic [31:0] stat_sync, stat_defer;
  logic [15:0] stat_err;
`endif

  fractal_sync_1d_rf_sched #(.N_REQ(N_REQ), .N_PORTS(N_PORTS), .ID_WIDTH(ID_WIDTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_id_i     (req_id),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_err_o    (rsp_err),
    .rf_id_o      (rf_id),
    .rf_check_o   (rf_check),
    .rf_present_i (rf_present),
    .rf_id_err_i  (rf_id_err),
    .rf_bypass_i  (rf_bypass),
    .rf_ignore_i  (rf_ignore)
`ifdef FRACTAL_SYNC_RF_SCHED_STATS_EN
    ,
    .stat_sync_o  (stat_sync),
    .stat_err_o   (stat_err),
    .stat_defer_o (stat_defer)
`endif
  );

  always #5 clk = ~clk;

  // RF model: one flag per id; same-id checks in one cycle pair up as bypass (first) / ignore (rest).
  int         n_regs = 4;
  logic [3:0] rf_q;

  always_comb begin
    logic dup_before, dup_after;
    rf_present = '0;
    rf_id_err  = '0;
    rf_bypass  = '0;
    rf_ignore  = '0;
    dup_before = 1'b0;
    dup_after  = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (rf_check[k]) begin
        if (int'(rf_id[k]) >= n_regs) begin
          rf_id_err[k] = 1'b1;
        end else begin
          dup_before = 1'b0;
          dup_after  = 1'b0;
          for (int j = 0; j < N_PORTS; j++)
            if (j != k && rf_check[j] && rf_id[j] == rf_id[k]) begin
              if (j < k) dup_before = 1'b1;
              else       dup_after  = 1'b1;
            end
          if (dup_before)            rf_ignore[k]  = 1'b1;
          else if (dup_after)        rf_bypass[k]  = 1'b1;
          else if (rf_q[rf_id[k]])   rf_present[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) rf_q <= '0;
    else
      for (int k = 0; k < N_PORTS; k++)
        if (rf_check[k] && !rf_id_err[k] && !rf_bypass[k] && !rf_ignore[k])
          rf_q[rf_id[k]] <= !rf_present[k];
  end

  typedef struct {int slot; bit err; int cyc;} exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0, miscompares = 0;

  task automatic expect_rsp(input int slot, input bit err, input int at);
    exp_t e;
    e.slot = slot; e.err = err; e.cyc = at;
    sb.push_back(e);
  endtask

  // Advance one cycle and score every response pulse against the queue.
  task automatic step();
    int hit;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      if (rsp_valid[i]) begin
        hit = -1;
        for (int q = 0; q < sb.size(); q++)
          if (sb[q].slot == i && sb[q].cyc == cyc) hit = q;
        vectors++;
        if (hit < 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected slot=%0d cyc=%0d got valid=1 want 0", i, cyc);
        end else begin
          if (rsp_err[i] !== sb[hit].err) begin
            miscompares++;
            $display("FAIL rsp_err slot=%0d cyc=%0d got %0b want %0b", i, cyc, rsp_err[i], sb[hit].err);
          end
          sb.delete(hit);
        end
      end
    end
    for (int q = sb.size() - 1; q >= 0; q--)
      if (sb[q].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_missing slot=%0d cyc=%0d got none want pulse at %0d", sb[q].slot, cyc, sb[q].cyc);
        sb.delete(q);
      end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_ni    = 1'b0;
    sb.delete();
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    step();
    vectors++;
    if (req_ready !== 4'b1111) begin miscompares++; $display("FAIL reset_ready got %b want 1111", req_ready); end
    vectors++;
    if (rsp_valid !== 4'b0000 || rsp_err !== 4'b0000) begin
      miscompares++; $display("FAIL reset_rsp got v=%b e=%b want 0000/0000", rsp_valid, rsp_err);
    end
    vectors++;
    if (rf_check !== 2'b00) begin miscompares++; $display("FAIL reset_check got %b want 00", rf_check); end
    vectors++;
    if (rf_id !== {2'd1, 2'd0}) begin miscompares++; $display("FAIL reset_rf_id got %h want 4", rf_id); end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_pair();
    int c;
    do_reset();
    c = cyc;
    req_valid = 4'b0001; req_id[0] = 2'd2;
    step();
    req_valid = '0;
    vectors++;
    if (rf_check !== 2'b01 || rf_id !== {2'd0, 2'd2}) begin
      miscompares++; $display("FAIL pair_grant got chk=%b id=%h want 01/2", rf_check, rf_id);
    end
    step();
    vectors++;
    if (req_ready !== 4'b1110 || rf_q[2] !== 1'b1) begin
      miscompares++; $display("FAIL pair_wait got ready=%b rf2=%b want 1110/1", req_ready, rf_q[2]);
    end
    while (cyc < c + 5) step();
    req_valid = 4'b0010; req_id[1] = 2'd2;
    expect_rsp(0, 1'b0, cyc + 2);
    expect_rsp(1, 1'b0, cyc + 2);
    step();
    req_valid = '0;
    step();
    step();
    vectors++;
    if (req_ready !== 4'b1111 || rf_q[2] !== 1'b0) begin
      miscompares++; $display("FAIL pair_done got ready=%b rf2=%b want 1111/0", req_ready, rf_q[2]);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    req_valid = 4'b0011; req_id[0] = 2'd1; req_id[1] = 2'd1;
    expect_rsp(0, 1'b0, cyc + 2);
    expect_rsp(1, 1'b0, cyc + 2);
    step();
    req_valid = '0;
    vectors++;
    if (rf_check !== 2'b11 || rf_id !== {2'd1, 2'd1}) begin
      miscompares++; $display("FAIL bypass_grant got chk=%b id=%h want 11/5", rf_check, rf_id);
    end
    step();
    step();
    vectors++;
    if (rf_q[1] !== 1'b0 || req_ready !== 4'b1111) begin
      miscompares++; $display("FAIL bypass_state got rf1=%b ready=%b want 0/1111", rf_q[1], req_ready);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111;
    req_id = {2'd3, 2'd2, 2'd1, 2'd0};
    step();
    req_valid = '0;
    vectors++;
    if (rf_check !== 2'b11 || rf_id !== {2'd1, 2'd0}) begin
      miscompares++; $display("FAIL rr_first got chk=%b id=%h want 11/4", rf_check, rf_id);
    end
    step();
    vectors++;
    if (rf_check !== 2'b11 || rf_id !== {2'd3, 2'd2}) begin
      miscompares++; $display("FAIL rr_second got chk=%b id=%h want 11/e", rf_check, rf_id);
    end
    step();
    vectors++;
    if (req_ready !== 4'b0000 || rf_q !== 4'b1111 || rf_check !== 2'b00) begin
      miscompares++; $display("FAIL rr_all_wait got ready=%b rf=%b chk=%b want 0000/1111/00", req_ready, rf_q, rf_check);
    end
`ifdef FRACTAL_SYNC_RF_SCHED_STATS_EN
    vectors++;
    if (stat_defer !== 32'd1) begin miscompares++; $display("FAIL rr_stat_defer got %0d want 1", stat_defer); end
`endif
  endtask

  task automatic test_deferral();
    int c;
    do_reset();
    vectors++;
    if (req_ready !== 4'b1111) begin miscompares++; $display("FAIL midop_reset got ready=%b want 1111", req_ready); end
    c = cyc;
    req_valid = 4'b0001; req_id[0] = 2'd3;
    step();
    req_valid = '0;
    step();
    step();
    req_valid = 4'b0110; req_id[1] = 2'd3; req_id[2] = 2'd3;
    expect_rsp(0, 1'b0, cyc + 2);
    expect_rsp(1, 1'b0, cyc + 2);
    step();
    req_valid = '0;
    vectors++;
    if (rf_check !== 2'b01 || rf_id !== {2'd0, 2'd3}) begin
      miscompares++; $display("FAIL defer_grant got chk=%b id=%h want 01/3", rf_check, rf_id);
    end
    step();
    vectors++;
    if (rf_check !== 2'b01 || rf_id[0] !== 2'd3 || req_ready[1] !== 1'b1) begin
      miscompares++; $display("FAIL defer_retry got chk=%b id0=%0d rdy1=%b want 01/3/1", rf_check, rf_id[0], req_ready[1]);
    end
    // slot 1 re-requests in the same cycle its response pulse is high
    req_valid = 4'b0010; req_id[1] = 2'd3;
    expect_rsp(1, 1'b0, cyc + 2);
    expect_rsp(2, 1'b0, cyc + 2);
    step();
    req_valid = '0;
    vectors++;
    if (req_ready !== 4'b1001) begin miscompares++; $display("FAIL defer_wait got ready=%b want 1001", req_ready); end
    step();
    step();
    vectors++;
    if (req_ready !== 4'b1111 || rf_q[3] !== 1'b0) begin
      miscompares++; $display("FAIL defer_done got ready=%b rf3=%b want 1111/0", req_ready, rf_q[3]);
    end
`ifdef FRACTAL_SYNC_RF_SCHED_STATS_EN
    vectors++;
    if (stat_defer !== 32'd1 || stat_sync !== 32'd4) begin
      miscompares++; $display("FAIL defer_stats got defer=%0d sync=%0d want 1/4", stat_defer, stat_sync);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [ID_WIDTH-1:0] id;
    do_reset();
    for (int it = 0; it < 4; it++) begin
      id = ID_WIDTH'($urandom_range(0, 3));
      req_valid = 4'b0011; req_id[0] = id; req_id[1] = id;
      expect_rsp(0, 1'b0, cyc + 2);
      expect_rsp(1, 1'b0, cyc + 2);
      step();
      req_valid = '0;
      step();
    end
    step();
    step();
    vectors++;
    if (req_ready !== 4'b1111 || rf_q !== 4'b0000) begin
      miscompares++; $display("FAIL b2b_idle got ready=%b rf=%b want 1111/0000", req_ready, rf_q);
    end
`ifdef FRACTAL_SYNC_RF_SCHED_STATS_EN
    vectors++;
    if (stat_sync !== 32'd8) begin miscompares++; $display("FAIL b2b_stat_sync got %0d want 8", stat_sync); end
`endif
  endtask

  task automatic test_id_err();
    n_regs = 2;
    do_reset();
    req_valid = 4'b0001; req_id[0] = 2'd3;
    expect_rsp(0, 1'b1, cyc + 2);
    step();
    req_valid = '0;
    vectors++;
    if (rf_id_err !== 2'b01) begin miscompares++; $display("FAIL iderr_status got %b want 01", rf_id_err); end
    step();
    step();
    vectors++;
    if (req_ready !== 4'b1111) begin miscompares++; $display("FAIL iderr_idle got ready=%b want 1111", req_ready); end
`ifdef FRACTAL_SYNC_RF_SCHED_STATS_EN
    vectors++;
    if (stat_err !== 16'd1 || stat_sync !== 32'd0) begin
      miscompares++; $display("FAIL iderr_stats got err=%0d sync=%0d want 1/0", stat_err, stat_sync);
    end
`endif
    n_regs = 4;
  endtask

  initial begin
    test_reset();
    test_pair();
    test_bypass();
    test_round_robin();
    test_deferral();
    test_back_to_back();
    test_id_err();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fractal_sync_1d_rf_sched.md
Name: fractal_sync_1d_rf_sched

Overview:
- Scheduler that shares one fractal_sync_1d_local_rf (N_PORTS ports) among N_REQ synchronisation requesters.
- Accepts one barrier request (an id) per requester and arbitrates requests onto the RF ports round-robin.
- Interprets the RF present/bypass/ignore/id_err outputs, parks first arrivals in a WAIT state, and releases both partners with a registered response when the partner arrives.

Parameters:
- N_REQ, 4, number of requesters; must be >= N_PORTS.
- N_PORTS, 2, RF port count; must be >= 2.
- ID_WIDTH, 2, barrier id width; elaboration assertion 2**ID_WIDTH >= N_PORTS.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  [N_REQ]  request valid.
- req_id_i  in  [N_REQ][ID_WIDTH]  barrier id.
- req_ready_o  out  [N_REQ]  requester slot is IDLE.
- rsp_valid_o  out  [N_REQ]  one-cycle response pulse.
- rsp_err_o  out  [N_REQ]  qualifies rsp_valid_o: 1 = id error, 0 = sync done.
- rf_id_o  out  [N_PORTS][ID_WIDTH]  RF port id.
- rf_check_o  out  [N_PORTS]  RF port check.
- rf_present_i, rf_id_err_i, rf_bypass_i, rf_ignore_i  in  [N_PORTS]  RF status (combinational from rf_id_o).

Behaviour:
- Per-requester FSM: IDLE -> ISSUE -> {WAIT | IDLE}, with WAIT -> IDLE.
  - Each slot holds a registered id.
  - req_ready_o = (state == IDLE).
  - Handshake: valid & ready captures the id; the slot enters ISSUE next cycle.
- Arbitration (combinational, every cycle):
  - Scan ISSUE slots starting at rr_ptr, wrapping modulo N_REQ.
  - Grant up to N_PORTS slots; port k carries the k-th grant.
  - Skip a candidate if its id is held by a WAIT slot and an earlier grant this cycle already has the same id (deferred, stays ISSUE).
  - rr_ptr <= (last granted index + 1) mod N_REQ; unchanged when there are no grants.
- Port drive:
  - Granted port: rf_id_o = slot id, rf_check_o = 1.
  - Unused port: rf_check_o = 0, rf_id_o = the j-th smallest id value not used by any granted port (j = unused-port ordinal). Unused ports never collide with anything, so the RF writes back its own state.
- Outcome per granted slot, evaluated in the grant cycle:
  - rf_id_err_i -> response err=1, IDLE.
  - rf_bypass_i or rf_ignore_i -> response err=0, IDLE.
  - rf_present_i -> response err=0, IDLE. The WAIT slot holding the same id also gets err=0 and goes IDLE.
  - Otherwise -> WAIT, no response.
- Response timing:
  - rsp_valid_o/rsp_err_o are registered, asserted exactly one cycle after the grant cycle, width one cycle.
  - No backpressure.
  - Earliest request-to-response latency: 2 cycles (capture edge, grant edge).
- A slot in IDLE may accept a new request in the same cycle its rsp_valid_o is high.
- Reset (asynchronous):
  - All slots IDLE, rr_ptr=0.
  - rsp_valid_o=0, rsp_err_o=0.
  - req_ready_o all 1 (combinational).
  - rf_check_o all 0; rf_id_o = 0,1,2,... by port.
- Reset mid-operation drops all WAIT slots; the RF resets in the same domain, so state stays consistent.
- A third arrival on an id already paired in the same cycle is prevented by the deferral rule.
- Two WAIT slots on one id cannot occur.

Optional Feature:
- Macro: FRACTAL_SYNC_RF_SCHED_STATS_EN.
- Defined: adds output ports, each saturating at all-ones and cleared by reset:
  - stat_sync_o [32]: count of err=0 responses.
  - stat_err_o [16]: count of err=1 responses.
  - stat_defer_o [32]: count of cycles with at least one ISSUE slot ungranted (port-limited or deferred).
- Undefined: these ports and their counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: after reset, req_ready_o=4'b1111, rsp_valid_o=0, rf_check_o=0, rf_id_o={0,1}.
- Pair via storage: req0 id=2 at cycle 0 -> req0 WAIT, no response. req1 id=2 at cycle 5 -> rsp_valid_o[0] and [1] high together at cycle 7 (err=0); RF entry 2 returns to 0.
- Bypass: req0 and req1 id=1 in the same cycle -> both granted (bypass/ignore) -> both responses err=0 2 cycles later; RF entry 1 stays 0.
- Round-robin: all 4 requesters valid, ids 0,1,2,3 -> grants {0,1} then {2,3}. All four end in WAIT; rr_ptr cycles 0 -> 2 -> 0.
- Deferral: req0 id=3 in WAIT; req1 and req2 id=3 arrive together -> req1 syncs with req0; req2 is deferred one cycle, then enters WAIT.
- Id error: RF built with N_REGS=2, req0 id=3 -> rf_id_err_i -> rsp_err_o[0]=1 pulse, slot back to IDLE. With STATS_EN defined, stat_err_o = 1.
